regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 50 +++++
 rtl/regfile_wb_arbiter_wb_slot.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register count and writeback request type for the
// register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 32;

  // One writeback request: destination register and value.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback requesters, the issue port and the
// register-file write / scoreboard outputs.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  // ALU writeback requester
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;

  // Load writeback requester
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;

  // Issue marks a destination register as awaiting a result
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;

  // Register-file write port and scoreboard
  logic                RegWrite;
  logic [ADDR_W-1:0]   rd;
  logic [DATA_W-1:0]   WD3;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    output issue_valid, issue_rd,
    input  RegWrite, rd, WD3, pending
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    input  issue_valid, issue_rd,
    output RegWrite, rd, WD3, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry holding buffer. The slot can refill at the same edge it is
// drained, so a granted requester never loses a cycle.
module wb_slot
  import regfile_wb_arbiter_pkg::*;
#(
  parameter type T = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  output T     out_data,
  input  logic out_pop
);

  logic full_q, full_d;
  T     data_q, data_d;
  logic accept;

  // Ready depends only on occupancy and the pop, never on in_valid.
  always_comb begin
    in_ready = !full_q || out_pop;
    accept   = in_valid && in_ready;
    full_d   = accept || (full_q && !out_pop);
    data_d   = accept ? in_data : data_q;
  end

  // Occupancy flag, cleared immediately by reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // Payload register.
  // NOTE: the payload is deliberately not reset; full_q alone qualifies it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and load paths, with a
// registered register-file write port and a pending-result scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t in0, in1, out0, out1, win;
  logic  full0, full1, rdy0, rdy1;
  logic  grant0, grant1, any_grant;

  // last_q = 1 means the load slot won the previous grant, so the ALU slot wins the next tie
  logic                last_q, last_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   wd3_q, wd3_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign in0 = {bus.req0_rd, bus.req0_data};
  assign in1 = {bus.req1_rd, bus.req1_data};

  wb_slot #(.T(slot_t)) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.req0_valid),
    .in_ready (rdy0),
    .in_data  (in0),
    .out_valid(full0),
    .out_data (out0),
    .out_pop  (grant0)
  );

  wb_slot #(.T(slot_t)) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.req1_valid),
    .in_ready (rdy1),
    .in_data  (in1),
    .out_valid(full1),
    .out_data (out1),
    .out_pop  (grant1)
  );

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;

  // Grant the only full slot, or on a tie the slot not granted last.
  always_comb begin
    grant0    = full0 && (!full1 || last_q);
    grant1    = full1 && !grant0;
    any_grant = grant0 || grant1;
    win       = grant0 ? out0 : out1;
  end

  // Next write-port and scoreboard values; an issue to the same register wins over a clear.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    last_d      = last_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wd3_d       = wd3_q;
    pending_d   = pending_q;
    if (any_grant) begin
      last_d      = grant1;
      reg_write_d = (win.rd != '0);
      rd_d        = win.rd;
      wd3_d       = win.data;
      if (win.rd != '0) pending_d[win.rd] = 1'b0;
    end
    if (bus.issue_valid && bus.issue_rd != '0) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Arbiter history, write port and scoreboard; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= 1'b1;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wd3_q       <= '0;
      pending_q   <= '0;
    end else begin
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wd3_q       <= wd3_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.RegWrite = reg_write_q;
  assign bus.rd       = rd_q;
  assign bus.WD3      = wd3_q;
  assign bus.pending  = pending_q;

endmodule
